video_io_ctl: RTL and testbench
===============================

Name: video_io_ctl

Overview:
- CPU-side control stage directly upstream of the display block. It decodes CPU OUT cycles to the video ports and drives the display's border, mode512, scroll and palette-write inputs.
- It converts the one-cycle palette port write into a setup/pulse/hold strobe sequence that satisfies the display's edge-triggered palette latch.
- It turns the display's asynchronous retrace output into a frame interrupt request for the CPU, with an acknowledge.

Parameters:
- PORT_MODE, 8'h02, port number for border index and mode512
- PORT_SCROLL, 8'h03, port number for vertical scroll
- PORT_PAL, 8'h0C, port number for palette data
- PAL_SETUP, 2, clk_sys cycles pal_data is stable before pal_we rises (1..15)
- PAL_WIDTH, 4, clk_sys cycles pal_we stays high (1..15)
- PAL_HOLD, 2, clk_sys cycles pal_data is held after pal_we falls (1..15)

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_addr  in  8  CPU I/O port address
- io_data  in  8  CPU output data
- io_wr  in  1  one-cycle OUT strobe; io_addr and io_data are valid in the same cycle
- retrace  in  1  display vertical sync, asynchronous to clk_sys
- int_en  in  1  CPU interrupt enable (INTE)
- inta  in  1  one-cycle interrupt acknowledge
- border  out  4  border colour index
- mode512  out  1  512-pixel mode select
- scroll  out  8  vertical scroll value
- pal_data  out  8  palette write data
- pal_we  out  1  palette write strobe; the display latches on its rising edge
- pal_busy  out  1  palette sequence in progress, or a write pending
- pal_ovf  out  1  sticky flag: a pending palette write was overwritten
- int_req  out  1  frame interrupt request

Behaviour:
- Reset: while reset_n=0, all state clears immediately.
  - border=0, mode512=0, scroll=8'hFF, pal_data=0, pal_we=0, pal_busy=0, pal_ovf=0, int_req=0.
  - FSM returns to IDLE, the pending slot is emptied, and both retrace synchronizer stages are forced to 0.
  - Reset during an active pulse drops pal_we asynchronously.
- Decode: exact 8-bit compare of io_addr when io_wr=1. Other addresses are ignored.
- Mode/scroll ports: outputs update on the clk_sys edge that samples io_wr (registered, 1-cycle latency).
  - PORT_MODE: border<=io_data[3:0], mode512<=io_data[4]; bits [7:5] are ignored.
  - PORT_SCROLL: scroll<=io_data.
- Palette FSM states: IDLE, SETUP, PULSE, HOLD. One down-counter (4 bits) is shared by SETUP, PULSE and HOLD.
  - IDLE: on a PORT_PAL write, pal_data<=io_data, counter<=PAL_SETUP-1, go to SETUP.
  - SETUP: pal_we=0. When the counter reaches 0, counter<=PAL_WIDTH-1 and go to PULSE.
  - PULSE: pal_we=1 (registered). When the counter reaches 0, counter<=PAL_HOLD-1 and go to HOLD.
  - HOLD: pal_we=0; pal_data must not change.
  - End of HOLD with the pending slot full: load pal_data from the slot, clear the slot, go to SETUP with no IDLE cycle.
  - End of HOLD with the slot empty: go to IDLE.
  - Timing: pal_we is high exactly PAL_WIDTH cycles; its rising edge comes PAL_SETUP cycles after the cycle following the io_wr.
- Pending slot: one entry.
  - A PORT_PAL write while the FSM is not in IDLE stores into the slot.
  - If the slot is already full, the new data overwrites it (last wins) and pal_ovf<=1.
  - pal_ovf clears only on reset.
- pal_busy = (state != IDLE) | slot_full.
- Interrupt:
  - retrace passes through a 2-FF synchronizer, then rising-edge detect (sync2 & ~sync3), so the edge is seen 3 cycles after the async rise.
  - A detected edge sets int_req.
  - inta=1 or int_en=0 clears int_req.
  - If an edge coincides with inta, set wins.
  - If an edge coincides with int_en=0, clear wins; no request is latched.
- Simultaneous io_wr and interrupt events are independent; there are no cross-effects.

Test Plan:
- Reset release, no stimulus -> scroll=FF, border=0, mode512=0, pal_we=0, int_req=0.
- io_wr to 02h with data 8'h3A -> next cycle border=4'hA, mode512=1; scroll stays FF. Then io_wr to 03h with data 8'h40 -> scroll=40.
- io_wr to 0Ch with data 8'h55, defaults -> pal_data=55 next cycle; pal_we high during cycles 3..6 after the write; pal_busy falls 9 cycles after the write; pal_data stays 55 throughout.
- Three back-to-back writes to 0Ch (11, 22, 33) -> strobes carry 11 then 33; pal_ovf=1; there is no IDLE gap between the two sequences.
- With int_en=1, retrace rises -> int_req=1 on the 3rd clk_sys edge. Then inta pulses -> int_req=0. A retrace edge coinciding with inta -> int_req stays 1.
- reset_n low mid-PULSE -> pal_we=0 immediately (asynchronously). After release the FSM is in IDLE, the slot is empty and pal_busy=0.

Source files
------------

// File: rtl/video_io_ctl.sv
// Purpose : CPU OUT-port decode for the display (border/mode512/scroll), palette strobe sequencer, frame interrupt.
// Latency : mode/scroll 1 cycle after io_wr; pal_we rises PAL_SETUP cycles after the cycle following io_wr; int_req 3 cycles after retrace rises.
// Backpressure: none on io_wr; one palette write queues in a pending slot while a strobe runs, later writes overwrite it and set pal_ovf.
//
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   io_addr/io_data/io_wr       CPU OUT cycle (one-cycle strobe)
//   retrace                     display vsync, asynchronous
//   int_en, inta                CPU interrupt enable / acknowledge
//   border, mode512, scroll     registered display controls
//   pal_data, pal_we            palette write bus to the display (latches on pal_we rise)
//   pal_busy, pal_ovf           palette sequencer status
//   int_req                     frame interrupt request
module video_io_ctl #(
    parameter logic [7:0]  PORT_MODE   = 8'h02,
    parameter logic [7:0]  PORT_SCROLL = 8'h03,
    parameter logic [7:0]  PORT_PAL    = 8'h0C,
    parameter int unsigned PAL_SETUP   = 2,
    parameter int unsigned PAL_WIDTH   = 4,
    parameter int unsigned PAL_HOLD    = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_data,
    input  logic       io_wr,
    input  logic       retrace,
    input  logic       int_en,
    input  logic       inta,
    output logic [3:0] border,
    output logic       mode512,
    output logic [7:0] scroll,
    output logic [7:0] pal_data,
    output logic       pal_we,
    output logic       pal_busy,
    output logic       pal_ovf,
    output logic       int_req
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [3:0] SETUP_LD = 4'(PAL_SETUP - 1);
    localparam logic [3:0] WIDTH_LD = 4'(PAL_WIDTH - 1);
    localparam logic [3:0] HOLD_LD  = 4'(PAL_HOLD - 1);

    logic [3:0] border_q,   border_d;
    logic       mode512_q,  mode512_d;
    logic [7:0] scroll_q,   scroll_d;
    logic [1:0] state_q,    state_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [7:0] pal_data_q, pal_data_d;
    logic       pal_we_q,   pal_we_d;
    logic       slot_full_q, slot_full_d;
    logic [7:0] slot_dat_q, slot_dat_d;
    logic       pal_ovf_q,  pal_ovf_d;
    logic       sync1_q,    sync1_d;
    logic       sync2_q,    sync2_d;
    logic       sync3_q,    sync3_d;
    logic       int_req_q,  int_req_d;

    logic wr_mode, wr_scroll, wr_pal, hold_done, retrace_rise;

    always_comb begin
        wr_mode   = io_wr && (io_addr == PORT_MODE);
        wr_scroll = io_wr && (io_addr == PORT_SCROLL);
        wr_pal    = io_wr && (io_addr == PORT_PAL);
        hold_done = (state_q == ST_HOLD) && (cnt_q == 4'd0);

        border_d    = border_q;
        mode512_d   = mode512_q;
        scroll_d    = scroll_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pal_data_d  = pal_data_q;
        slot_full_d = slot_full_q;
        slot_dat_d  = slot_dat_q;
        pal_ovf_d   = pal_ovf_q;

        if (wr_mode) begin
            border_d  = io_data[3:0];
            mode512_d = io_data[4];
        end
        if (wr_scroll) begin
            scroll_d = io_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_pal) begin
                    pal_data_d = io_data;
                    cnt_d      = SETUP_LD;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = WIDTH_LD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    // Chain straight into the next strobe: queued data first,
                    // otherwise a write arriving in this very cycle.
                    if (slot_full_q) begin
                        pal_data_d  = slot_dat_q;
                        slot_full_d = 1'b0;
                        cnt_d       = SETUP_LD;
                        state_d     = ST_SETUP;
                    end else if (wr_pal) begin
                        pal_data_d = io_data;
                        cnt_d      = SETUP_LD;
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Writes during a running sequence go to the slot. At the end of HOLD
        // with an empty slot the write was launched directly above; with a
        // full slot the old entry was just consumed, so no overflow.
        if (wr_pal && (state_q != ST_IDLE) && !(hold_done && !slot_full_q)) begin
            slot_dat_d  = io_data;
            slot_full_d = 1'b1;
            if (slot_full_q && !hold_done) begin
                pal_ovf_d = 1'b1;
            end
        end

        // Registered strobe: high in every cycle the FSM sits in PULSE.
        pal_we_d = (state_d == ST_PULSE);

        sync1_d      = retrace;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        retrace_rise = sync2_q & ~sync3_q;

        // Disable beats a new edge; a new edge beats acknowledge.
        int_req_d = int_req_q;
        if (!int_en) begin
            int_req_d = 1'b0;
        end else if (retrace_rise) begin
            int_req_d = 1'b1;
        end else if (inta) begin
            int_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            border_q    <= 4'd0;
            mode512_q   <= 1'b0;
            scroll_q    <= 8'hFF;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            pal_data_q  <= 8'd0;
            pal_we_q    <= 1'b0;
            slot_full_q <= 1'b0;
            slot_dat_q  <= 8'd0;
            pal_ovf_q   <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            int_req_q   <= 1'b0;
        end else begin
            border_q    <= border_d;
            mode512_q   <= mode512_d;
            scroll_q    <= scroll_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pal_data_q  <= pal_data_d;
            pal_we_q    <= pal_we_d;
            slot_full_q <= slot_full_d;
            slot_dat_q  <= slot_dat_d;
            pal_ovf_q   <= pal_ovf_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            int_req_q   <= int_req_d;
        end
    end

    assign border   = border_q;
    assign mode512  = mode512_q;
    assign scroll   = scroll_q;
    assign pal_data = pal_data_q;
    assign pal_we   = pal_we_q;
    assign pal_busy = (state_q != ST_IDLE) | slot_full_q;
    assign pal_ovf  = pal_ovf_q;
    assign int_req  = int_req_q;

endmodule

// File: tb/tb_video_io_ctl.sv
// Purpose : self-checking bench for video_io_ctl with a cycle-level reference model.
// Latency : outputs compared every cycle on the falling edge after the sampling edge.
// Backpressure: n/a (bench drives the CPU side freely).
module tb_video_io_ctl;

    localparam int S = 2;
    localparam int W = 4;
    localparam int H = 2;
    localparam int L = S + W + H;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] io_addr = 8'd0;
    logic [7:0] io_data = 8'd0;
    logic       io_wr   = 1'b0;
    logic       retrace = 1'b0;
    logic       int_en  = 1'b0;
    logic       inta    = 1'b0;
    logic [3:0] border;
    logic       mode512;
    logic [7:0] scroll;
    logic [7:0] pal_data;
    logic       pal_we;
    logic       pal_busy;
    logic       pal_ovf;
    logic       int_req;

    video_io_ctl dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .io_addr (io_addr),
        .io_data (io_data),
        .io_wr   (io_wr),
        .retrace (retrace),
        .int_en  (int_en),
        .inta    (inta),
        .border  (border),
        .mode512 (mode512),
        .scroll  (scroll),
        .pal_data(pal_data),
        .pal_we  (pal_we),
        .pal_busy(pal_busy),
        .pal_ovf (pal_ovf),
        .int_req (int_req)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: a palette sequence is described by its age
    // (cycles since launch), not by FSM phases.
    logic [3:0] m_border;
    logic       m_mode;
    logic [7:0] m_scroll;
    bit         m_active;
    int         m_age;
    logic [7:0] m_data;
    bit         m_slot;
    logic [7:0] m_slot_dat;
    bit         m_ovf;
    bit         m_int;
    bit         rh[$];   // retrace samples, newest first

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_border   = 4'd0;
        m_mode     = 1'b0;
        m_scroll   = 8'hFF;
        m_active   = 1'b0;
        m_age      = 0;
        m_data     = 8'd0;
        m_slot     = 1'b0;
        m_slot_dat = 8'd0;
        m_ovf      = 1'b0;
        m_int      = 1'b0;
        rh         = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit wr_pal;
        bit fin;
        bit e;
        if (io_wr && io_addr == 8'h02) begin
            m_border = io_data[3:0];
            m_mode   = io_data[4];
        end
        if (io_wr && io_addr == 8'h03) m_scroll = io_data;

        wr_pal = io_wr && (io_addr == 8'h0C);
        fin    = m_active && (m_age == L);
        if (!m_active && wr_pal) begin
            m_data   = io_data;
            m_active = 1'b1;
            m_age    = 1;
        end else if (fin && (m_slot || wr_pal)) begin
            if (m_slot) begin
                m_data = m_slot_dat;
                m_slot = wr_pal;
                if (wr_pal) m_slot_dat = io_data;
            end else begin
                m_data = io_data;
            end
            m_age = 1;
        end else if (m_active) begin
            if (wr_pal) begin
                if (m_slot) m_ovf = 1'b1;
                m_slot     = 1'b1;
                m_slot_dat = io_data;
            end
            if (fin) m_active = 1'b0;
            else     m_age++;
        end

        // Rise becomes visible as an interrupt on the third sampling edge.
        rh.push_front(retrace);
        void'(rh.pop_back());
        e = rh[2] && !rh[3];
        if (!int_en)   m_int = 1'b0;
        else if (e)    m_int = 1'b1;
        else if (inta) m_int = 1'b0;
    endtask

    task automatic compare_all();
        logic exp_we;
        exp_we = m_active && (m_age > S) && (m_age <= S + W);
        check_val("border",   border,   m_border);
        check_val("mode512",  mode512,  m_mode);
        check_val("scroll",   scroll,   m_scroll);
        check_val("pal_data", pal_data, m_data);
        check_val("pal_we",   pal_we,   exp_we);
        check_val("pal_busy", pal_busy, m_active || m_slot);
        check_val("pal_ovf",  pal_ovf,  m_ovf);
        check_val("int_req",  int_req,  m_int);
    endtask

    // Called at a falling edge with inputs already set; returns at the next
    // falling edge after checking, with the one-cycle strobes dropped.
    task automatic step();
        @(posedge clk_sys);
        model_step();
        @(negedge clk_sys);
        compare_all();
        io_wr = 1'b0;
        inta  = 1'b0;
    endtask

    task automatic io_out(input logic [7:0] a, input logic [7:0] d);
        io_wr   = 1'b1;
        io_addr = a;
        io_data = d;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    logic [7:0] strobes[$];
    bit         prev_we;
    bit         gap;
    logic       exp_b;
    int         guard;

    task automatic sample_strobe();
        if (pal_we && !prev_we) strobes.push_back(pal_data);
        if (!pal_busy && strobes.size() < 2) gap = 1'b1;
        prev_we = pal_we;
    endtask

    initial begin
        do_reset();

        // Reset state
        step();
        check_val("rst_scroll",  scroll,  8'hFF);
        check_val("rst_border",  border,  4'h0);
        check_val("rst_mode512", mode512, 1'b0);
        check_val("rst_pal_we",  pal_we,  1'b0);
        check_val("rst_int_req", int_req, 1'b0);

        // Mode and scroll ports
        io_out(8'h02, 8'h3A);
        check_val("mode_border",  border,  4'hA);
        check_val("mode_mode512", mode512, 1'b1);
        check_val("mode_scroll",  scroll,  8'hFF);
        io_out(8'h03, 8'h40);
        check_val("scroll_40", scroll, 8'h40);
        io_out(8'h05, 8'hEE);   // unmapped port: no effect
        check_val("unmapped_scroll", scroll, 8'h40);

        // Single palette write, observed cycle by cycle
        io_out(8'h0C, 8'h55);
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) step();
            exp_b = (i >= 3 && i <= 6);
            check_val("pal1_we", pal_we, exp_b);
            exp_b = (i <= 8);
            check_val("pal1_busy", pal_busy, exp_b);
            check_val("pal1_data", pal_data, 8'h55);
        end

        // Three back-to-back palette writes
        strobes.delete();
        prev_we = 1'b0;
        gap     = 1'b0;
        io_out(8'h0C, 8'h11); sample_strobe();
        io_out(8'h0C, 8'h22); sample_strobe();
        io_out(8'h0C, 8'h33); sample_strobe();
        guard = 0;
        while (pal_busy && guard < 40) begin
            step();
            sample_strobe();
            guard++;
        end
        check_val("b2b_done",    guard < 40, 1'b1);
        check_val("b2b_count",   strobes.size(), 2);
        if (strobes.size() == 2) begin
            check_val("b2b_first",  strobes[0], 8'h11);
            check_val("b2b_second", strobes[1], 8'h33);
        end
        check_val("b2b_ovf", pal_ovf, 1'b1);
        check_val("b2b_gap", gap, 1'b0);

        // Interrupt
        int_en = 1'b1;
        repeat (4) step();
        retrace = 1'b1;
        step(); check_val("int_e1", int_req, 1'b0);
        step(); check_val("int_e2", int_req, 1'b0);
        step(); check_val("int_e3", int_req, 1'b1);
        inta = 1'b1;
        step(); check_val("int_ack", int_req, 1'b0);
        retrace = 1'b0;
        repeat (4) step();
        retrace = 1'b1;
        step(); step();
        inta = 1'b1;
        step(); check_val("int_edge_vs_inta", int_req, 1'b1);
        int_en = 1'b0;
        step(); check_val("int_dis", int_req, 1'b0);
        int_en = 1'b1;
        retrace = 1'b0;
        repeat (4) step();
        retrace = 1'b1;
        step(); step();
        int_en = 1'b0;
        step(); check_val("int_edge_vs_dis", int_req, 1'b0);
        int_en = 1'b1;
        step(); check_val("int_no_latch", int_req, 1'b0);

        // Reset in the middle of a strobe
        io_out(8'h0C, 8'hA7);
        guard = 0;
        while (!pal_we && guard < 10) begin
            step();
            guard++;
        end
        check_val("pre_rst_we", pal_we, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_we",   pal_we,   1'b0);
        check_val("rst_async_busy", pal_busy, 1'b0);
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();
        check_val("post_rst_busy", pal_busy, 1'b0);
        check_val("post_rst_we",   pal_we,   1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                io_wr = 1'b1;
                case ($urandom_range(0, 3))
                    0:       io_addr = 8'h02;
                    1:       io_addr = 8'h03;
                    2:       io_addr = 8'h0C;
                    default: io_addr = 8'($urandom);
                endcase
                io_data = 8'($urandom);
            end
            if ($urandom_range(0, 5) == 0) retrace = ~retrace;
            inta   = ($urandom_range(0, 7) == 0);
            int_en = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
